// File: rtl/serial_divisibility_by_n_fsm.sv
// ---------------------------------------------------------------------------
// serial_divisibility_by_n_fsm
//
// Serial divisibility checker for an arbitrary DIVISOR. One bit per
// in_valid cycle is folded into a running remainder. div_by_n reports
// divisibility every cycle. A frame that ends with last produces a one-cycle
// res_valid pulse and a held res_div verdict.
//
// Parameters:
//   DIVISOR  modulus N (>= 1)
//   CNT_W    width of the saturating bit counter
//   R_W      remainder width, max(1, clog2(DIVISOR)) (derived)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous restart of the current frame
//   in_valid   in   new_bit is valid this cycle
//   new_bit    in   serial data bit
//   last       in   with in_valid: this bit ends the frame
//   remainder  out  running value mod DIVISOR (registered)
//   div_by_n   out  remainder == 0
//   bit_cnt    out  bits accepted in the current frame (saturating)
//   res_valid  out  one-cycle pulse: frame verdict available
//   res_div    out  verdict of the last completed frame (held)
//
// Build option:
//   SERIAL_DIV_LSB_FIRST_EN  stream is LSB-first; adds a weight register
//   holding 2**k mod N for the k-th bit of the frame. Default is MSB-first.
// ---------------------------------------------------------------------------
module serial_divisibility_by_n_fsm #(
  parameter int DIVISOR = 5,
  parameter int CNT_W   = 8,
  localparam int R_W    = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             new_bit,
  input  logic             last,
  output logic [R_W-1:0]   remainder,
  output logic             div_by_n,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             res_valid,
  output logic             res_div
);

  generate
    if (DIVISOR < 1) begin : g_bad_divisor
      $error("serial_divisibility_by_n_fsm: DIVISOR must be >= 1");
    end
  endgenerate

  // DIVISOR always fits in R_W+1 bits, which is also wide enough for 2r+b.
  localparam logic [R_W:0]   N_EXT = (R_W+1)'(DIVISOR);

  logic [R_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_div_q, res_div_d;

  // Frame start values after an optional clr in the same cycle.
  logic [R_W-1:0]   rem_base;
  logic [CNT_W-1:0] cnt_base;
  logic [R_W-1:0]   rem_step;
  logic [CNT_W-1:0] cnt_step;
  logic [R_W:0]     step_sum;

`ifdef SERIAL_DIV_LSB_FIRST_EN
  localparam logic [R_W-1:0] W_ONE = (DIVISOR == 1) ? '0 : R_W'(1);

  logic [R_W-1:0] w_q, w_d;
  logic [R_W-1:0] w_base;
  logic [R_W-1:0] w_step;
  logic [R_W:0]   w_dbl;
`endif

  always_comb begin
    rem_base    = clr ? '0 : rem_q;
    cnt_base    = clr ? '0 : bit_cnt_q;
    cnt_step    = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);

`ifdef SERIAL_DIV_LSB_FIRST_EN
    w_base      = clr ? W_ONE : w_q;
    // r' = r + b*w ; both operands < N so one conditional subtract reduces it.
    step_sum    = {1'b0, rem_base} + (new_bit ? {1'b0, w_base} : '0);
    w_dbl       = {w_base, 1'b0};
    w_step      = (w_dbl >= N_EXT) ? R_W'(w_dbl - N_EXT) : w_dbl[R_W-1:0];
`else
    // r' = 2r + b, which is below 2N.
    step_sum    = {rem_base, new_bit};
`endif
    rem_step    = (step_sum >= N_EXT) ? R_W'(step_sum - N_EXT)
                                      : step_sum[R_W-1:0];

    rem_d       = rem_base;
    bit_cnt_d   = cnt_base;
    res_valid_d = 1'b0;
    res_div_d   = res_div_q;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    w_d         = w_base;
`endif

    if (in_valid) begin
      if (last) begin
        // Verdict on the completed frame; next frame starts clean.
        res_valid_d = 1'b1;
        res_div_d   = (rem_step == '0);
        rem_d       = '0;
        bit_cnt_d   = '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        w_d         = W_ONE;
`endif
      end else begin
        rem_d       = rem_step;
        bit_cnt_d   = cnt_step;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        w_d         = w_step;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      bit_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      res_div_q   <= 1'b0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
      w_q         <= W_ONE;
`endif
    end else begin
      rem_q       <= rem_d;
      bit_cnt_q   <= bit_cnt_d;
      res_valid_q <= res_valid_d;
      res_div_q   <= res_div_d;
`ifdef SERIAL_DIV_LSB_FIRST_EN
      w_q         <= w_d;
`endif
    end
  end

  assign remainder = rem_q;
  assign div_by_n  = (rem_q == '0);
  assign bit_cnt   = bit_cnt_q;
  assign res_valid = res_valid_q;
  assign res_div   = res_div_q;

endmodule
